// File: rtl/id_ex_stage_pkg.sv
// Package shared by the ID/EX stage files.
// Holds the default datapath widths, the ALU operation codes, and the
// operand-source select encodings for ALU inputs A and B.
package id_ex_stage_pkg;

  localparam int WORD_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic A_SEL_RS1 = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;
  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of every signal exchanged between the ID/EX stage and its
// neighbours: decoded instruction from ID, flush/hold control, MEM/WB
// producer triples, and the registered/forwarded EX outputs.
//   master  : the surrounding pipeline (drives ID fields, control, MEM/WB)
//   slave   : the ID/EX stage itself
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int WORD_WIDTH     = WORD_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) ();
  logic                      id_valid;
  logic [WORD_WIDTH-1:0]     id_pc;
  logic [WORD_WIDTH-1:0]     id_rs1_data;
  logic [WORD_WIDTH-1:0]     id_rs2_data;
  logic [WORD_WIDTH-1:0]     id_imm;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic [3:0]                id_alu_ctl;
  logic                      id_a_sel;
  logic                      id_b_sel;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      id_mem_write;
  logic                      flush;
  logic                      ex_hold;
  logic                      mem_reg_write;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic [WORD_WIDTH-1:0]     mem_data;
  logic                      wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [WORD_WIDTH-1:0]     wb_data;
  logic                      id_stall;
  logic                      ex_valid;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic [WORD_WIDTH-1:0]     ex_pc;
  logic [WORD_WIDTH-1:0]     alu_a;
  logic [WORD_WIDTH-1:0]     alu_b;
  logic [3:0]                alu_ctl;
  logic [WORD_WIDTH-1:0]     ex_store_data;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_alu_ctl, id_a_sel, id_b_sel, id_reg_write, id_mem_read,
           id_mem_write, flush, ex_hold, mem_reg_write, mem_rd, mem_data,
           wb_reg_write, wb_rd, wb_data,
    input  id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd,
           ex_pc, alu_a, alu_b, alu_ctl, ex_store_data
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_alu_ctl, id_a_sel, id_b_sel, id_reg_write, id_mem_read,
           id_mem_write, flush, ex_hold, mem_reg_write, mem_rd, mem_data,
           wb_reg_write, wb_rd, wb_data,
    output id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd,
           ex_pc, alu_a, alu_b, alu_ctl, ex_store_data
  );
endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// Operand bypass mux for one EX source register.
// Ports: i_rs (source index), i_reg_data (value captured at ID),
//        i_mem_* / i_wb_* (producer write-enable, rd, data),
//        o_data (forwarded operand).
// MEM is the younger producer and therefore wins over WB; x0 never forwards.
module fwd_sel
  import id_ex_stage_pkg::*;
#(
  parameter int WORD_WIDTH     = WORD_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic [REG_ADDR_WIDTH-1:0] i_rs,
  input  logic [WORD_WIDTH-1:0]     i_reg_data,
  input  logic                      i_mem_we,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd,
  input  logic [WORD_WIDTH-1:0]     i_mem_data,
  input  logic                      i_wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd,
  input  logic [WORD_WIDTH-1:0]     i_wb_data,
  output logic [WORD_WIDTH-1:0]     o_data
);

  function automatic logic rd_hit(input logic                      we,
                                  input logic [REG_ADDR_WIDTH-1:0] rd,
                                  input logic [REG_ADDR_WIDTH-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

  always_comb begin
    if (rd_hit(i_mem_we, i_mem_rd, i_rs))     o_data = i_mem_data;
    else if (rd_hit(i_wb_we, i_wb_rd, i_rs))  o_data = i_wb_data;
    else                                      o_data = i_reg_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble
// insertion, and flush/hold control.
// Ports: clk, rst (sync, active-high), bus (id_ex_stage_if.slave):
//   in : id_* decoded instruction, flush, ex_hold, mem_*/wb_* producers
//   out: id_stall, ex_* registered control/fields, alu_a/alu_b/alu_ctl,
//        ex_store_data (forwarded rs2)
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WORD_WIDTH     = WORD_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  logic                      r_vld_p1;
  logic                      r_reg_write_p1;
  logic                      r_mem_read_p1;
  logic                      r_mem_write_p1;
  logic                      r_a_sel_p1;
  logic                      r_b_sel_p1;
  logic [WORD_WIDTH-1:0]     r_pc_p1;
  logic [WORD_WIDTH-1:0]     r_rs1_data_p1;
  logic [WORD_WIDTH-1:0]     r_rs2_data_p1;
  logic [WORD_WIDTH-1:0]     r_imm_p1;
  logic [REG_ADDR_WIDTH-1:0] r_rs1_p1;
  logic [REG_ADDR_WIDTH-1:0] r_rs2_p1;
  logic [REG_ADDR_WIDTH-1:0] r_rd_p1;
  logic [3:0]                r_alu_ctl_p1;

  logic                      w_lu;
  logic [WORD_WIDTH-1:0]     w_rs1_cap;
  logic [WORD_WIDTH-1:0]     w_rs2_cap;
  logic [WORD_WIDTH-1:0]     w_fwd_rs1;
  logic [WORD_WIDTH-1:0]     w_fwd_rs2;

  function automatic logic wb_hit(input logic [REG_ADDR_WIDTH-1:0] rs);
    return bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == rs);
  endfunction

  // The rs2 compare is applied even for immediate-form instructions; the
  // occasional spurious stall is cheaper than decoding operand usage here.
  assign w_lu = r_vld_p1 && r_mem_read_p1 && (r_rd_p1 != '0) && bus.id_valid &&
                ((bus.id_rs1 == r_rd_p1) || (bus.id_rs2 == r_rd_p1));

  // The register file is not write-first, so a same-cycle WB write must be
  // picked up here or it would be lost once WB retires.
  assign w_rs1_cap = wb_hit(bus.id_rs1) ? bus.wb_data : bus.id_rs1_data;
  assign w_rs2_cap = wb_hit(bus.id_rs2) ? bus.wb_data : bus.id_rs2_data;

  // ---- ID -> EX register boundary ----
  // Priority: rst > flush > ex_hold > load-use > load. rst and bubble share
  // the same all-zero image with ALU_ADD.
  always_ff @(posedge clk) begin
    if (rst || bus.flush || (!bus.ex_hold && w_lu)) begin
      r_vld_p1       <= 1'b0;
      r_reg_write_p1 <= 1'b0;
      r_mem_read_p1  <= 1'b0;
      r_mem_write_p1 <= 1'b0;
      r_a_sel_p1     <= A_SEL_RS1;
      r_b_sel_p1     <= B_SEL_RS2;
      r_pc_p1        <= '0;
      r_rs1_data_p1  <= '0;
      r_rs2_data_p1  <= '0;
      r_imm_p1       <= '0;
      r_rs1_p1       <= '0;
      r_rs2_p1       <= '0;
      r_rd_p1        <= '0;
      r_alu_ctl_p1   <= ALU_ADD;
    end else if (!bus.ex_hold) begin
      r_vld_p1       <= bus.id_valid;
      r_reg_write_p1 <= bus.id_reg_write;
      r_mem_read_p1  <= bus.id_mem_read;
      r_mem_write_p1 <= bus.id_mem_write;
      r_a_sel_p1     <= bus.id_a_sel;
      r_b_sel_p1     <= bus.id_b_sel;
      r_pc_p1        <= bus.id_pc;
      r_rs1_data_p1  <= w_rs1_cap;
      r_rs2_data_p1  <= w_rs2_cap;
      r_imm_p1       <= bus.id_imm;
      r_rs1_p1       <= bus.id_rs1;
      r_rs2_p1       <= bus.id_rs2;
      r_rd_p1        <= bus.id_rd;
      r_alu_ctl_p1   <= bus.id_alu_ctl;
    end
  end

  fwd_sel #(.WORD_WIDTH(WORD_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs1 (
    .i_rs(r_rs1_p1), .i_reg_data(r_rs1_data_p1),
    .i_mem_we(bus.mem_reg_write), .i_mem_rd(bus.mem_rd), .i_mem_data(bus.mem_data),
    .i_wb_we(bus.wb_reg_write), .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data),
    .o_data(w_fwd_rs1)
  );

  fwd_sel #(.WORD_WIDTH(WORD_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs2 (
    .i_rs(r_rs2_p1), .i_reg_data(r_rs2_data_p1),
    .i_mem_we(bus.mem_reg_write), .i_mem_rd(bus.mem_rd), .i_mem_data(bus.mem_data),
    .i_wb_we(bus.wb_reg_write), .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data),
    .o_data(w_fwd_rs2)
  );

  // Flush overrides any stall reason: the ID instruction is being discarded.
  assign bus.id_stall      = !bus.flush && (bus.ex_hold || w_lu);
  assign bus.ex_valid      = r_vld_p1;
  assign bus.ex_reg_write  = r_reg_write_p1;
  assign bus.ex_mem_read   = r_mem_read_p1;
  assign bus.ex_mem_write  = r_mem_write_p1;
  assign bus.ex_rd         = r_rd_p1;
  assign bus.ex_pc         = r_pc_p1;
  assign bus.alu_ctl       = r_alu_ctl_p1;
  assign bus.alu_a         = (r_a_sel_p1 == A_SEL_PC)  ? r_pc_p1  : w_fwd_rs1;
  assign bus.alu_b         = (r_b_sel_p1 == B_SEL_IMM) ? r_imm_p1 : w_fwd_rs2;
  assign bus.ex_store_data = w_fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reference model of the EX latch plus directed
// vectors with hand-computed expectations.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk;
  logic rst;
  id_ex_stage_if #(.WORD_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  id_ex_stage #(.WORD_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  ctl;
    logic        as, bs, rw, mr, mw;
  } ex_t;

  ex_t m;
  bit  m_init = 0;

  function automatic logic m_lu();
    return m.v && m.mr && m.rd != 0 && bus.id_valid &&
           (bus.id_rs1 == m.rd || bus.id_rs2 == m.rd);
  endfunction

  // Newest producer wins; x0 always reads the captured value.
  function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] stored);
    if (rs == 0) return stored;
    if (bus.mem_reg_write && bus.mem_rd == rs) return bus.mem_data;
    if (bus.wb_reg_write && bus.wb_rd == rs) return bus.wb_data;
    return stored;
  endfunction

  function automatic logic [31:0] m_cap(input logic [4:0] rs, input logic [31:0] rf);
    if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == rs) return bus.wb_data;
    return rf;
  endfunction

  always @(posedge clk) begin
    ex_t nxt;
    nxt = m;
    if (rst) begin
      nxt = '0; nxt.ctl = ALU_ADD; m_init = 1;
    end else if (bus.flush || (!bus.ex_hold && m_lu())) begin
      nxt = '0; nxt.ctl = ALU_ADD;
    end else if (!bus.ex_hold) begin
      nxt.v = bus.id_valid; nxt.pc = bus.id_pc; nxt.imm = bus.id_imm;
      nxt.d1 = m_cap(bus.id_rs1, bus.id_rs1_data);
      nxt.d2 = m_cap(bus.id_rs2, bus.id_rs2_data);
      nxt.rs1 = bus.id_rs1; nxt.rs2 = bus.id_rs2; nxt.rd = bus.id_rd;
      nxt.ctl = bus.id_alu_ctl; nxt.as = bus.id_a_sel; nxt.bs = bus.id_b_sel;
      nxt.rw = bus.id_reg_write; nxt.mr = bus.id_mem_read; nxt.mw = bus.id_mem_write;
    end
    m = nxt;
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_id_stall", 32'(bus.id_stall), 32'(!bus.flush && (bus.ex_hold || m_lu())));
      chk("m_ex_valid", 32'(bus.ex_valid), 32'(m.v));
      chk("m_ex_ctl_bits", {29'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write},
          {29'd0, m.rw, m.mr, m.mw});
      chk("m_ex_rd", 32'(bus.ex_rd), 32'(m.rd));
      chk("m_ex_pc", bus.ex_pc, m.pc);
      chk("m_alu_ctl", 32'(bus.alu_ctl), 32'(m.ctl));
      chk("m_alu_a", bus.alu_a, m.as ? m.pc : m_fwd(m.rs1, m.d1));
      chk("m_alu_b", bus.alu_b, m.bs ? m.imm : m_fwd(m.rs2, m.d2));
      chk("m_store", bus.ex_store_data, m_fwd(m.rs2, m.d2));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [3:0] ctl, input logic as, input logic bs,
                        input logic rw, input logic mr, input logic mw);
    bus.id_valid = v; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rs1_data = d1;
    bus.id_rs2 = rs2; bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_rd = rd;
    bus.id_alu_ctl = ctl; bus.id_a_sel = as; bus.id_b_sel = bs;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
  endtask

  task automatic set_fwd(input logic mw, input logic [4:0] mrd, input logic [31:0] md,
                         input logic ww, input logic [4:0] wrd, input logic [31:0] wd);
    bus.mem_reg_write = mw; bus.mem_rd = mrd; bus.mem_data = md;
    bus.wb_reg_write = ww; bus.wb_rd = wrd; bus.wb_data = wd;
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0; bus.ex_hold = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    // Reset held two cycles while ID presents a real instruction.
    set_id(1, 32'h40, 1, 32'hdead, 2, 32'hbeef, 32'h9, 3, ALU_SUB, 0, 1, 1, 0, 0);
    tick(); tick();
    chk("rst_ex_valid", 32'(bus.ex_valid), 0);
    chk("rst_alu_ctl", 32'(bus.alu_ctl), 32'(ALU_ADD));
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_id_stall", 32'(bus.id_stall), 0);
    rst = 1'b0;

    // Pass-through, immediate operand B.
    set_id(1, 32'h100, 1, 32'd5, 2, 32'h66, 32'd7, 4, ALU_ADD, 0, 1, 1, 0, 0);
    tick();
    chk("pass_alu_a", bus.alu_a, 32'd5);
    chk("pass_alu_b", bus.alu_b, 32'd7);
    chk("pass_ex_valid", 32'(bus.ex_valid), 1);
    chk("pass_ex_pc", bus.ex_pc, 32'h100);

    // Forward priority on rs1 = x3.
    set_id(1, 32'h104, 3, 32'h33, 0, 32'h44, 0, 7, ALU_OR, 0, 0, 1, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
    set_fwd(1, 3, 32'h11, 1, 3, 32'h22);
    #1 chk("fwd_mem_wins", bus.alu_a, 32'h11);
    chk("fwd_store_x0", bus.ex_store_data, 32'h44);
    bus.mem_reg_write = 1'b0;
    #1 chk("fwd_wb", bus.alu_a, 32'h22);
    bus.wb_reg_write = 1'b0;
    #1 chk("fwd_none", bus.alu_a, 32'h33);

    // Same with x0: never forwards.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h108, 0, 32'h55, 0, 0, 0, 7, ALU_ADD, 0, 0, 1, 0, 0);
    tick();
    set_fwd(1, 0, 32'h11, 1, 0, 32'h22);
    #1 chk("fwd_x0", bus.alu_a, 32'h55);

    // Capture-time WB bypass.
    set_fwd(0, 0, 0, 1, 9, 32'hbb);
    set_id(1, 32'h10c, 9, 32'haa, 0, 0, 0, 1, ALU_ADD, 0, 0, 1, 0, 0);
    tick();
    bus.wb_reg_write = 1'b0;
    #1 chk("cap_wb", bus.alu_a, 32'hbb);

    // Load-use: lw x5 then add x6, x5, x1.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h110, 2, 32'h1000, 0, 0, 32'd4, 5, ALU_ADD, 0, 1, 1, 1, 0);
    tick();
    set_id(1, 32'h114, 5, 32'h99, 1, 32'h10, 0, 6, ALU_ADD, 0, 0, 1, 0, 0);
    #1 chk("lu_stall", 32'(bus.id_stall), 1);
    tick();
    chk("lu_bubble_valid", 32'(bus.ex_valid), 0);
    chk("lu_bubble_stall", 32'(bus.id_stall), 0);
    tick();
    set_fwd(1, 5, 32'h500, 0, 0, 0);
    #1 chk("lu_fwd_a", bus.alu_a, 32'h500);
    chk("lu_add_rd", 32'(bus.ex_rd), 6);
    chk("lu_add_b", bus.alu_b, 32'h10);

    // Flush together with load-use and hold.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h120, 2, 32'h1000, 0, 0, 32'd4, 5, ALU_ADD, 0, 1, 1, 1, 0);
    tick();
    set_id(1, 32'h124, 5, 32'h99, 1, 32'h10, 0, 6, ALU_ADD, 0, 0, 1, 0, 0);
    bus.ex_hold = 1'b1; bus.flush = 1'b1;
    #1 chk("flush_stall", 32'(bus.id_stall), 0);
    tick();
    chk("flush_valid", 32'(bus.ex_valid), 0);
    bus.flush = 1'b0; bus.ex_hold = 1'b0;

    // Hold for three cycles while ID changes.
    set_id(1, 32'h200, 1, 32'h1234, 0, 0, 0, 8, ALU_XOR, 0, 0, 1, 0, 0);
    tick();
    chk("hold_load_pc", bus.ex_pc, 32'h200);
    bus.ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 32'h300 + 32'(4 * i), 5'(i + 2), 32'(i), 0, 0, 0, 5'(9 + i),
             ALU_SUB, 0, 0, 1, 0, 0);
      #1 chk("hold_stall", 32'(bus.id_stall), 1);
      tick();
      chk("hold_pc", bus.ex_pc, 32'h200);
      chk("hold_rd", 32'(bus.ex_rd), 8);
      chk("hold_alu_a", bus.alu_a, 32'h1234);
    end
    bus.ex_hold = 1'b0;
    set_id(1, 32'h400, 1, 32'h77, 0, 0, 0, 12, ALU_ADD, 0, 0, 1, 0, 0);
    #1 chk("release_stall", 32'(bus.id_stall), 0);
    tick();
    chk("release_pc", bus.ex_pc, 32'h400);
    chk("release_rd", 32'(bus.ex_rd), 12);
    chk("release_alu_a", bus.alu_a, 32'h77);

    // Reset asserted while a load-use stall is pending.
    set_id(1, 32'h500, 2, 32'h1000, 0, 0, 32'd4, 5, ALU_ADD, 0, 1, 1, 1, 0);
    tick();
    set_id(1, 32'h504, 5, 32'h99, 1, 32'h10, 0, 6, ALU_ADD, 0, 0, 1, 0, 0);
    #1 chk("rst_mid_stall_pre", 32'(bus.id_stall), 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", 32'(bus.ex_valid), 0);
    chk("rst_mid_stall", 32'(bus.id_stall), 0);
    rst = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
